// File: rtl/microwave_countdown.sv
// microwave_countdown: BCD m:ss cooking timer (IDLE/RUNNING/PAUSED/DONE), one decrement per CLK_PER_SEC cycles.
// Optional completion buzzer is built only when COUNTDOWN_ALARM_EN is defined; otherwise alarm is tied low.
module microwave_countdown #(
    parameter int CLK_PER_SEC   = 100,
    parameter int ALARM_SECONDS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic [3:0] units_of_seconds_in,
    input  logic [3:0] tens_of_seconds_in,
    input  logic [3:0] units_of_minutes_in,
    output logic [3:0] units_of_seconds,
    output logic [3:0] tens_of_seconds,
    output logic [3:0] units_of_minutes,
    output logic       heating,
    output logic       done,
    output logic       alarm
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);

`ifdef COUNTDOWN_ALARM_EN
    localparam int ALARM_CYCLES = ALARM_SECONDS * CLK_PER_SEC;
    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
    logic [AW-1:0] alarm_cnt;
`else
    assign alarm = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

    state_t        state;
    logic [PW-1:0] prescale;

    logic [3:0] ld_us;
    logic [3:0] ld_ts;
    logic [3:0] ld_um;
    logic       entry_nz;
    logic       at_last_sec;

    always_comb begin
        ld_us       = (units_of_seconds_in > 4'd9) ? 4'd9 : units_of_seconds_in;
        ld_ts       = (tens_of_seconds_in  > 4'd5) ? 4'd5 : tens_of_seconds_in;
        ld_um       = (units_of_minutes_in > 4'd9) ? 4'd9 : units_of_minutes_in;
        entry_nz    = |{units_of_seconds_in, tens_of_seconds_in, units_of_minutes_in};
        // the only value whose decrement lands on 0:00
        at_last_sec = (units_of_seconds == 4'd1) && (tens_of_seconds == 4'd0) &&
                      (units_of_minutes == 4'd0);
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state            <= IDLE;
            prescale         <= '0;
            units_of_seconds <= 4'd0;
            tens_of_seconds  <= 4'd0;
            units_of_minutes <= 4'd0;
            heating          <= 1'b0;
`ifdef COUNTDOWN_ALARM_EN
            alarm            <= 1'b0;
            alarm_cnt        <= '0;
`endif
        end else if (cancel) begin
            state            <= IDLE;
            prescale         <= '0;
            units_of_seconds <= 4'd0;
            tens_of_seconds  <= 4'd0;
            units_of_minutes <= 4'd0;
            heating          <= 1'b0;
`ifdef COUNTDOWN_ALARM_EN
            alarm            <= 1'b0;
            alarm_cnt        <= '0;
`endif
        end else begin
`ifdef COUNTDOWN_ALARM_EN
            if (alarm) begin
                if (alarm_cnt == '0) alarm <= 1'b0;
                else                 alarm_cnt <= alarm_cnt - 1'b1;
            end
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
`ifdef COUNTDOWN_ALARM_EN
                        alarm <= 1'b0;
`endif
                        if (entry_nz) begin
                            state            <= RUNNING;
                            prescale         <= '0;
                            units_of_seconds <= ld_us;
                            tens_of_seconds  <= ld_ts;
                            units_of_minutes <= ld_um;
                            heating          <= 1'b1;
                        end
                    end
                end
                RUNNING: begin
                    if (pause) begin
                        state   <= PAUSED;
                        heating <= 1'b0;
                    end else if (prescale == PRE_LAST) begin
                        prescale <= '0;
                        if (units_of_seconds != 4'd0) begin
                            units_of_seconds <= units_of_seconds - 4'd1;
                        end else if (tens_of_seconds != 4'd0) begin
                            tens_of_seconds  <= tens_of_seconds - 4'd1;
                            units_of_seconds <= 4'd9;
                        end else begin
                            units_of_minutes <= units_of_minutes - 4'd1;
                            tens_of_seconds  <= 4'd5;
                            units_of_seconds <= 4'd9;
                        end
                        if (at_last_sec) begin
                            state   <= DONE;
                            heating <= 1'b0;
                            done    <= 1'b1;
`ifdef COUNTDOWN_ALARM_EN
                            alarm     <= 1'b1;
                            alarm_cnt <= ALARM_LAST;
`endif
                        end
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state   <= RUNNING;
                        heating <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_countdown.sv
// tb_microwave_countdown: directed scenarios plus random stimulus against a seconds-based reference model.
module tb_microwave_countdown;

    localparam int CPS   = 4;
    localparam int ASECS = 3;

    logic       clk = 1'b0;
    logic       rst, start, pause, cancel;
    logic [3:0] us_in, ts_in, um_in;
    logic [3:0] us, ts, um;
    logic       heating, done, alarm;

    int total = 0;
    int bad   = 0;

    microwave_countdown #(.CLK_PER_SEC(CPS), .ALARM_SECONDS(ASECS)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .cancel(cancel),
        .units_of_seconds_in(us_in), .tens_of_seconds_in(ts_in), .units_of_minutes_in(um_in),
        .units_of_seconds(us), .tens_of_seconds(ts), .units_of_minutes(um),
        .heating(heating), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time as a plain count of seconds.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_secs = 0;
    int      m_phase = 0;
    int      m_alarm_left = 0;
    bit      m_done = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit s, input bit p,
                              input int u, input int t, input int m);
        m_done = 0;
        if (r || c) begin
            m_state = M_IDLE; m_secs = 0; m_phase = 0; m_alarm_left = 0;
            return;
        end
        if (m_alarm_left > 0) m_alarm_left--;
        case (m_state)
            M_IDLE, M_DONE: if (s) begin
                m_alarm_left = 0;
                if (u + t + m != 0) begin
                    m_secs  = clampv(m, 9) * 60 + clampv(t, 5) * 10 + clampv(u, 9);
                    m_phase = 0;
                    m_state = M_RUN;
                end
            end
            M_RUN: if (p) m_state = M_PAUSE;
                   else if (m_phase == CPS - 1) begin
                       m_phase = 0;
                       m_secs--;
                       if (m_secs == 0) begin
                           m_state = M_DONE;
                           m_done  = 1;
`ifdef COUNTDOWN_ALARM_EN
                           m_alarm_left = ASECS * CPS;
`endif
                       end
                   end else m_phase++;
            M_PAUSE: if (s) m_state = M_RUN;
            default: ;
        endcase
    endtask

    function automatic int dut_digits();
        return {20'd0, um, ts, us};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, compare just after.
    task automatic cycle(input bit r, input bit c, input bit s, input bit p,
                         input int u, input int t, input int m);
        int exp_d;
        rst = r; cancel = c; start = s; pause = p;
        us_in = 4'(u); ts_in = 4'(t); um_in = 4'(m);
        @(posedge clk);
        model_step(r, c, s, p, u, t, m);
        #1;
        exp_d = (m_secs / 60) * 256 + ((m_secs % 60) / 10) * 16 + (m_secs % 10);
        chk("digits", dut_digits(), exp_d);
        chk("heating", int'(heating), int'(m_state == M_RUN));
        chk("done", int'(done), int'(m_done));
        chk("alarm", int'(alarm), int'(m_alarm_left > 0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int acnt;
        int exp_alarm;
        int dcnt;
        rst = 1; start = 0; pause = 0; cancel = 0;
        us_in = 0; ts_in = 0; um_in = 0;

        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("rst_digits", dut_digits(), 0);
        chk("rst_heat", int'(heating), 0);

        // 0:03 countdown: decrements at +4, +8, +12 cycles after start
        cycle(0, 0, 1, 0, 3, 0, 0);
        chk("ld003", dut_digits(), 'h003);
        idle_cycles(4);
        chk("tick002", dut_digits(), 'h002);
        idle_cycles(4);
        chk("tick001", dut_digits(), 'h001);
        dcnt = 0;
        idle_cycles(4);
        chk("end000", dut_digits(), 'h000);
        chk("done_pulse", int'(done), 1);
        chk("heat_off", int'(heating), 0);
        acnt = int'(alarm);
        for (int i = 0; i < 15; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            acnt += int'(alarm);
            dcnt += int'(done);
        end
        chk("done_once", dcnt, 0);
`ifdef COUNTDOWN_ALARM_EN
        exp_alarm = ASECS * CPS;
`else
        exp_alarm = 0;
`endif
        chk("alarm_len", acnt, exp_alarm);

        // 1:00 borrows to 0:59; 9:99 clamps to 9:59
        cycle(0, 0, 1, 0, 0, 0, 1);
        idle_cycles(4);
        chk("borrow", dut_digits(), 'h059);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 9, 9, 9);
        chk("clamp", dut_digits(), 'h959);
        cycle(0, 0, 1, 0, 15, 15, 15);
        chk("ign_start_run", dut_digits(), 'h959);
        cycle(0, 1, 0, 0, 0, 0, 0);

        // pause at 0:05 with prescaler phase 2, resume keeps the phase
        cycle(0, 0, 1, 0, 7, 0, 0);
        idle_cycles(8);
        chk("at005", dut_digits(), 'h005);
        idle_cycles(2);
        for (int i = 0; i < 20; i++) cycle(0, 0, i == 0, 1, 0, 0, 0);
        chk("paused_hold", dut_digits(), 'h005);
        chk("paused_heat", int'(heating), 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("resume_heat", int'(heating), 1);
        idle_cycles(1);
        chk("resume_phase", dut_digits(), 'h005);
        idle_cycles(1);
        chk("resume_tick", dut_digits(), 'h004);

        // cancel while running, then start with 0:00 entered
        cycle(0, 1, 0, 0, 0, 0, 0);
        chk("cancel_digits", dut_digits(), 0);
        chk("cancel_heat", int'(heating), 0);
        chk("cancel_done", int'(done), 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("zero_start", int'(heating), 0);

        // start+pause in IDLE loads; cancel+start wins for cancel
        cycle(0, 0, 1, 1, 2, 0, 0);
        chk("sp_heat", int'(heating), 1);
        chk("sp_digits", dut_digits(), 'h002);
        cycle(0, 1, 1, 0, 5, 0, 0);
        chk("cs_heat", int'(heating), 0);
        chk("cs_digits", dut_digits(), 0);

        // reset mid-countdown
        cycle(0, 0, 1, 0, 1, 0, 0);
        idle_cycles(3);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("rst_nodone", int'(done), 0);
        idle_cycles(2);

        // random traffic, biased toward short times so runs complete
        for (int i = 0; i < 4000; i++) begin
            bit r, c, s, p;
            int u, t, m;
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 11) == 0);
            p = ($urandom_range(0, 19) == 0);
            u = int'($urandom_range(0, 15));
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            m = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : 0;
            if ($urandom_range(0, 7) == 0) begin u = 0; t = 0; m = 0; end
            cycle(r, c, s, p, u, t, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microwave_countdown.md
MICROWAVE_COUNTDOWN -- requirements
Module: microwave_countdown

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 100, clock cycles per one-second tick (bench overrides to 4).
REQ-002 SHALL have parameter ALARM_SECONDS, default 3, seconds the alarm sounds after completion.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  load the entered time, or resume from PAUSED.
REQ-006 pause  input  1  suspend the countdown.
REQ-007 cancel  input  1  abort and clear.
REQ-008 units_of_seconds_in  input  4  entered BCD seconds units from the timer input block.
REQ-009 tens_of_seconds_in  input  4  entered BCD seconds tens.
REQ-010 units_of_minutes_in  input  4  entered BCD minutes.
REQ-011 units_of_seconds  output  4  remaining seconds units, BCD.
REQ-012 tens_of_seconds  output  4  remaining seconds tens, BCD.
REQ-013 units_of_minutes  output  4  remaining minutes, BCD.
REQ-014 heating  output  1  high exactly while in RUNNING.
REQ-015 done  output  1  one-cycle pulse on reaching 0:00.
REQ-016 alarm  output  1  completion buzzer (see Configuration).

Function
REQ-017 SHALL implement the states IDLE, RUNNING, PAUSED and DONE, all outputs registered.
REQ-018 Input priority SHALL be rst > cancel > start > pause, evaluated every cycle.
REQ-019 In IDLE or DONE, start with a nonzero entered time SHALL load the digits and go to RUNNING; loaded digits appear on the outputs the next cycle.
REQ-020 Digit clamping on load: any units digit >9 SHALL load as 9; tens >5 SHALL load as 5.
REQ-021 Start with an entered time of 0:00 SHALL be ignored; state is unchanged.
REQ-022 Loading SHALL clear the prescaler; the first decrement occurs CLK_PER_SEC cycles after the start cycle.
REQ-023 In RUNNING the prescaler SHALL count 0..CLK_PER_SEC-1; the terminal count is a tick and the counter wraps to 0.
REQ-024 Decrement on tick SHALL follow BCD borrow rules:
- units_of_seconds>0: decrement it.
- else tens_of_seconds>0: decrement tens; units becomes 9.
- else units_of_minutes>0: decrement minutes; tens becomes 5, units becomes 9.
REQ-025 The decrement that yields 0:00 SHALL move the block to DONE and assert done for exactly that next cycle.
REQ-026 In RUNNING, pause SHALL go to PAUSED; a tick in the same cycle is suppressed and the prescaler is held.
REQ-027 In PAUSED, start SHALL resume RUNNING without reloading, keeping the prescaler value; pause in PAUSED has no effect.
REQ-028 Start or pause in RUNNING (other than per REQ-026), and pause in IDLE or DONE, SHALL be ignored.
REQ-029 Cancel in any state SHALL go to IDLE, clear digits and prescaler, and drop alarm, all the next cycle.
REQ-030 Input digits SHALL be sampled only on the start-load cycle; later changes are ignored.

Reset
REQ-031 On rst, the block SHALL enter IDLE with all digits 0, prescaler 0, heating 0, done 0 and alarm 0.
REQ-032 Reset mid-countdown SHALL abort without a done pulse.

Configuration
REQ-033 Macro COUNTDOWN_ALARM_EN SHALL control the alarm.
- Defined: alarm rises with done and stays high for ALARM_SECONDS*CLK_PER_SEC cycles or until cancel/start/rst.
- Undefined: alarm is tied 0 and its counter is not built.

Verification
REQ-034 Load 0:03, start (CLK_PER_SEC=4): outputs 0:03 next cycle; 0:02, 0:01, 0:00 at +4, +8, +12 cycles; done pulses once; heating falls with the 0:00 transition.
REQ-035 Load 1:00, run one tick: outputs 0:59; load 9:99 digits: clamped to 9:59.
REQ-036 Pause at 0:05 for 20 cycles, then start: value holds at 0:05 while paused; the countdown resumes with the remaining prescaler phase.
REQ-037 Cancel during RUNNING: next cycle IDLE, 0:00, heating 0, no done pulse; a start with 0:00 entered stays in IDLE.
REQ-038 Simultaneous start+pause in IDLE: loads and runs; simultaneous cancel+start: ends in IDLE.
REQ-039 With COUNTDOWN_ALARM_EN, ALARM_SECONDS=3 and CLK_PER_SEC=4: alarm high for 12 cycles after done; without the macro, alarm stays 0.
